reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Produces a programmable alternating reset waveform (assert L cycles, release L cycles, repeated N times).
//  Sits directly upstream of the reset-consuming stage and drives its reset net.
//  Replaces hand-written #delay toggling with a synthesizable, clocked generator.
//  Reports progress through busy/done/pulse_cnt.
// PARAMETERS
//  HOLD_CYCLES  20  default phase length in clk cycles, used when hold_len==0
//  CNT_W        8   width of hold_len, num_pulses, pulse_cnt and internal counters
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-low reset (0 = reset)
//  start       in   1      request a sequence; sampled only in IDLE
//  abort       in   1      terminate an active sequence
//  hold_len    in   CNT_W  phase length in cycles; 0 selects HOLD_CYCLES; latched at start
//  num_pulses  in   CNT_W  number of assert/release pairs; latched at start
//  rst_out     out  1      generated reset, active-high (1 = downstream held in reset)
//  busy        out  1      high while a sequence is running
//  done        out  1      one-cycle pulse on normal completion
//  pulse_cnt   out  CNT_W  number of completed assert/release pairs in the current/last run
// BEHAVIOUR
//  Reset: reset==0 at a clk edge gives state=IDLE, rst_out=1, busy=0, done=0, pulse_cnt=0.
//   Counters clear. Reset takes priority over every other input.
//  All outputs are registered and have no combinational path from inputs.
//  FSM states: IDLE, ASSERT, RELEASE, FINISH.
//  IDLE:
//   - rst_out holds its last value; busy=0.
//   - start==1 latches L (hold_len, or HOLD_CYCLES if hold_len==0) and P=num_pulses.
//   - P>0: next state ASSERT. P==0: next state FINISH with rst_out=0.
//  ASSERT:
//   - rst_out=1, busy=1, for exactly L cycles.
//   - Then go to RELEASE.
//  RELEASE:
//   - rst_out=0 for exactly L cycles.
//   - On the last cycle, pulse_cnt increments.
//   - If pulse_cnt+1 < P, return to ASSERT; otherwise go to FINISH.
//  FINISH: one cycle with done=1, busy=0, rst_out=0; then IDLE.
//  Latency:
//   - start sampled at edge t gives rst_out=1 and busy=1 visible after edge t+1.
//   - done is visible after edge t+2*L*P+1.
//   - rst_out is 0 on leaving the sequence.
//  pulse_cnt clears to 0 when a new start is accepted.
//  start while busy (ASSERT/RELEASE/FINISH) is ignored, not queued.
//   hold_len and num_pulses changes mid-run have no effect.
//  abort in ASSERT or RELEASE: next cycle IDLE, rst_out=0, busy=0, no done pulse.
//   pulse_cnt keeps its value.
//  abort in IDLE or FINISH has no effect. start and abort together in IDLE: start wins.
//  Phase counter is CNT_W wide and counts 0..L-1. L up to 2^CNT_W-1 is supported without wrap.
//  Reset asserted mid-sequence aborts immediately to reset values (rst_out=1).
// TESTING
//  1. Hold reset=0 for 3 cycles -> rst_out=1, busy=0, done=0, pulse_cnt=0.
//     Release reset -> outputs stay put.
//  2. start=1 for 1 cycle with hold_len=0, num_pulses=2 ->
//     rst_out 1 for 20 cycles, 0 for 20, 1 for 20, 0 for 20.
//     done pulse at cycle 81; pulse_cnt=2.
//  3. hold_len=3, num_pulses=1 -> rst_out=1 for 3 cycles, 0 for 3 cycles.
//     done at cycle 7; a start pulse during cycle 4 is ignored.
//  4. num_pulses=0 with start -> no ASSERT phase, rst_out=0.
//     done=1 after edge t+1; busy stays 0.
//  5. hold_len=5, num_pulses=3, abort at cycle 12 ->
//     next cycle rst_out=0, busy=0, done never pulses, pulse_cnt=1.
//  6. reset=0 at cycle 8 of a hold_len=5 run -> rst_out=1, busy=0, pulse_cnt=0 next cycle.
//     A new start afterwards runs normally.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: clocked generator for an alternating reset waveform.
// After an accepted start it drives rst_out high for L cycles and low for L cycles,
// P times over, then pulses done for one cycle. L and P are latched at start.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-low reset (0 = reset)
//   start      - request a sequence; only honoured in idle
//   abort      - stop a running sequence without a done pulse
//   hold_len   - phase length in cycles; 0 selects HOLD_CYCLES
//   num_pulses - number of assert/release pairs
//   rst_out    - generated reset, active-high
//   busy       - high while a sequence runs
//   done       - one-cycle pulse on normal completion
//   pulse_cnt  - completed assert/release pairs in the current/last run
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             rst_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] np_q, np_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             rst_out_q, rst_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             phase_last;
  logic [CNT_W-1:0] pcnt_inc;

  assign phase_last = (phase_q == len_q - CNT_W'(1));
  // pcnt_q < np_q whenever this is used, so the increment cannot wrap
  assign pcnt_inc   = pcnt_q + CNT_W'(1);

  // Output registers are loaded from the current state, so every output lags the
  // state register by one cycle: start at edge t shows rst_out/busy after edge t+1.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    np_d      = np_q;
    phase_d   = phase_q;
    pcnt_d    = pcnt_q;
    rst_out_d = rst_out_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = (hold_len == '0) ? CNT_W'(HOLD_CYCLES) : hold_len;
          np_d    = num_pulses;
          pcnt_d  = '0;
          phase_d = '0;
          state_d = (num_pulses != '0) ? StAssert : StFinish;
        end
      end
      StAssert: begin
        rst_out_d = 1'b1;
        busy_d    = 1'b1;
        if (abort) begin
          state_d   = StIdle;
          rst_out_d = 1'b0;
          busy_d    = 1'b0;
        end else if (phase_last) begin
          phase_d = '0;
          state_d = StRelease;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      StRelease: begin
        rst_out_d = 1'b0;
        busy_d    = 1'b1;
        if (abort) begin
          // abort wins over the pair-complete increment on the last cycle
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (phase_last) begin
          phase_d = '0;
          pcnt_d  = pcnt_inc;
          state_d = (pcnt_inc < np_q) ? StAssert : StFinish;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      StFinish: begin
        rst_out_d = 1'b0;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      np_q      <= '0;
      phase_q   <= '0;
      pcnt_q    <= '0;
      rst_out_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      np_q      <= np_d;
      phase_q   <= phase_d;
      pcnt_q    <= pcnt_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed opening (reset, default-length run, ignored
// start) followed by randomized start/abort/reset traffic, all checked every cycle
// against a timeline model that derives the waveform from the start time, L and P.
module tb_reset_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int          HOLD  = 20;
  localparam int          NCYC  = 6000;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [CNT_W-1:0] hold_len, num_pulses;
  logic             rst_out, busy, done;
  logic [CNT_W-1:0] pulse_cnt;

  always #5 clk = ~clk;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .hold_len  (hold_len),
    .num_pulses(num_pulses),
    .rst_out   (rst_out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Timeline model: a run accepted at edge t0 with length ml and count mp occupies
  // edges t0+1 .. t0+2*ml*mp (waveform), done after t0+2*ml*mp+1, idle again after.
  bit act;
  int t0, ml, mp;
  bit e_rst, e_busy, e_done;
  int e_pulse;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic model_edge();
    int  d, span;
    bit  idle_now;
    if (!reset) begin
      act     = 1'b0;
      e_rst   = 1'b1;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_pulse = 0;
    end else begin
      idle_now = !act;
      if (act) begin
        d    = cyc - t0;
        span = 2 * ml * mp;
        if (abort && d >= 1 && d <= span) begin
          act    = 1'b0;
          e_rst  = 1'b0;
          e_busy = 1'b0;
          e_done = 1'b0;
        end else if (d <= span) begin
          e_rst   = (((d - 1) / ml) % 2) == 0;
          e_busy  = 1'b1;
          e_done  = 1'b0;
          e_pulse = d / (2 * ml);
        end else if (d == span + 1) begin
          e_rst   = 1'b0;
          e_busy  = 1'b0;
          e_done  = 1'b1;
          e_pulse = mp;
        end else begin
          act      = 1'b0;
          idle_now = 1'b1;
        end
      end
      if (idle_now) begin
        e_busy = 1'b0;
        e_done = 1'b0;
        if (start) begin
          act     = 1'b1;
          t0      = cyc;
          ml      = (hold_len == 0) ? HOLD : int'(hold_len);
          mp      = int'(num_pulses);
          e_pulse = 0;
        end
      end
    end
  endtask

  task automatic drive(input int c);
    int k;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    hold_len   = CNT_W'($urandom_range(0, 255));
    num_pulses = CNT_W'($urandom_range(0, 255));
    if (c < 3) begin
      reset = 1'b0;
    end else if (c == 6) begin
      start      = 1'b1;
      hold_len   = '0;
      num_pulses = CNT_W'(2);
    end else if (c == 30) begin
      start = 1'b1;  // mid-run, must be ignored
    end else if (c == 100) begin
      start      = 1'b1;
      hold_len   = CNT_W'(255);
      num_pulses = CNT_W'(1);
    end else if (c > 620) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      k     = $urandom_range(0, 19);
      if (k == 0) begin
        hold_len   = '0;
        num_pulses = CNT_W'($urandom_range(0, 2));
      end else if (k == 1) begin
        hold_len   = CNT_W'($urandom_range(100, 255));
        num_pulses = CNT_W'(1);
      end else begin
        hold_len   = CNT_W'($urandom_range(1, 5));
        num_pulses = CNT_W'($urandom_range(0, 4));
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    hold_len   = '0;
    num_pulses = '0;
    act        = 1'b0;
    e_rst      = 1'b1;
    e_busy     = 1'b0;
    e_done     = 1'b0;
    e_pulse    = 0;
    for (int c = 0; c < NCYC; c++) begin
      drive(c);
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_val("rst_out", 32'(rst_out), 32'(e_rst));
      check_val("busy", 32'(busy), 32'(e_busy));
      check_val("done", 32'(done), 32'(e_done));
      check_val("pulse_cnt", 32'(pulse_cnt), 32'(e_pulse));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
